// File: rtl/cgra_cmem_loader.sv
// rtl/cgra_cmem_loader.sv - OBI read-to-write copy engine that fills CGRA context memory
// Optional feature: define CGRA_CMEM_LOADER_CHECKSUM_EN for an XOR checksum of written words.
module cgra_cmem_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] src_base_i,
    input  logic [ADDR_WIDTH-1:0] cm_base_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic [31:0]           checksum_o,
    output logic                  src_req_o,
    output logic [ADDR_WIDTH-1:0] src_addr_o,
    input  logic                  src_gnt_i,
    input  logic                  src_rvalid_i,
    input  logic [31:0]           src_rdata_i,
    output logic                  cm_req_o,
    output logic [ADDR_WIDTH-1:0] cm_addr_o,
    output logic                  cm_we_o,
    output logic [3:0]            cm_be_o,
    output logic [31:0]           cm_wdata_o,
    input  logic                  cm_gnt_i
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_base_q, src_base_d;
    logic [ADDR_WIDTH-1:0] cm_base_q, cm_base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  rd_issued_q, rd_issued_d;
    logic [LEN_WIDTH-1:0]  wr_done_q, wr_done_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic                  src_pend_q, src_pend_d;
    logic                  cm_pend_q, cm_pend_d;
    logic                  aborted_q, aborted_d;
    logic [31:0]           mem_q [FIFO_DEPTH];
    logic [31:0]           mem_d [FIFO_DEPTH];

    logic                  src_req, cm_req, src_hs, pop, rsp, push;
    logic [CW:0]           occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A request that was raised but not granted stays up (src_pend/cm_pend) even across abort.
    always_comb begin
        occupancy = {1'b0, outstanding_q} + {1'b0, count_q};
        src_req   = src_pend_q
                  | ((state_q == RUN) && (rd_issued_q < len_q) && (occupancy < DEPTH_C));
        cm_req    = ((state_q == RUN) && (count_q != '0)) || ((state_q == DRAIN) && cm_pend_q);
        src_hs    = src_req & src_gnt_i;
        pop       = cm_req & cm_gnt_i;
        rsp       = src_rvalid_i && (outstanding_q != '0) && ((state_q == RUN) || (state_q == DRAIN));
        push      = rsp && (state_q == RUN);
    end

    always_comb begin
        state_d       = state_q;
        src_base_d    = src_base_q;
        cm_base_d     = cm_base_q;
        len_d         = len_q;
        aborted_d     = aborted_q;
        mem_d         = mem_q;
        rd_issued_d   = rd_issued_q + LEN_WIDTH'(src_hs);
        wr_done_d     = wr_done_q + LEN_WIDTH'(pop);
        outstanding_d = outstanding_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        src_pend_d    = src_req & ~src_gnt_i;
        cm_pend_d     = cm_req & ~cm_gnt_i;

        if (src_hs && !rsp) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!src_hs && rsp) begin
            outstanding_d = outstanding_q - 1'b1;
        end
        if (push) begin
            mem_d[wr_ptr_q] = src_rdata_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    aborted_d = 1'b0;
                    if (len_i != '0) begin
                        src_base_d    = src_base_i;
                        cm_base_d     = cm_base_i;
                        len_d         = len_i;
                        rd_issued_d   = '0;
                        wr_done_d     = '0;
                        outstanding_d = '0;
                        count_d       = '0;
                        rd_ptr_d      = '0;
                        wr_ptr_d      = '0;
                        state_d       = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // Finishing the last word wins over a simultaneous abort.
                if (pop && (wr_done_q + 1'b1 == len_q)) begin
                    state_d = DONE;
                end else if (abort_i) begin
                    state_d   = DRAIN;
                    aborted_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!cm_pend_q) begin
                    count_d  = '0;
                    rd_ptr_d = wr_ptr_q;
                end
                if ((outstanding_q == '0) && !src_pend_q && !cm_pend_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            src_base_q    <= '0;
            cm_base_q     <= '0;
            len_q         <= '0;
            rd_issued_q   <= '0;
            wr_done_q     <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            src_pend_q    <= 1'b0;
            cm_pend_q     <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_base_q    <= src_base_d;
            cm_base_q     <= cm_base_d;
            len_q         <= len_d;
            rd_issued_q   <= rd_issued_d;
            wr_done_q     <= wr_done_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            src_pend_q    <= src_pend_d;
            cm_pend_q     <= cm_pend_d;
            aborted_q     <= aborted_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifdef CGRA_CMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == IDLE) && start_i) begin
            checksum_d = '0;
        end else if (pop) begin
            checksum_d = checksum_q ^ mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = 32'd0;
`endif

    // Buses idle at zero when no request is raised.
    assign busy_o     = (state_q == RUN) || (state_q == DRAIN);
    assign done_o     = (state_q == DONE);
    assign aborted_o  = (state_q == DONE) && aborted_q;
    assign src_req_o  = src_req;
    assign src_addr_o = src_req ? (src_base_q + (ADDR_WIDTH'(rd_issued_q) << 2)) : '0;
    assign cm_req_o   = cm_req;
    assign cm_addr_o  = cm_req ? (cm_base_q + (ADDR_WIDTH'(wr_done_q) << 2)) : '0;
    assign cm_wdata_o = cm_req ? mem_q[rd_ptr_q] : '0;
    assign cm_we_o    = 1'b1;
    assign cm_be_o    = 4'hF;
endmodule

// File: tb/tb_cgra_cmem_loader.sv
// tb/tb_cgra_cmem_loader.sv - randomized self-checking bench for cgra_cmem_loader
module tb_cgra_cmem_loader;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int FD = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni, start_i, abort_i;
    logic [AW-1:0] src_base_i, cm_base_i;
    logic [LW-1:0] len_i;
    logic          busy_o, done_o, aborted_o;
    logic [31:0]   checksum_o;
    logic          src_req_o, src_gnt_i, src_rvalid_i;
    logic [AW-1:0] src_addr_o;
    logic [31:0]   src_rdata_i;
    logic          cm_req_o, cm_we_o, cm_gnt_i;
    logic [AW-1:0] cm_addr_o;
    logic [3:0]    cm_be_o;
    logic [31:0]   cm_wdata_o;

    always #5 clk_i = ~clk_i;

    cgra_cmem_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .src_base_i(src_base_i), .cm_base_i(cm_base_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .checksum_o(checksum_o),
        .src_req_o(src_req_o), .src_addr_o(src_addr_o), .src_gnt_i(src_gnt_i),
        .src_rvalid_i(src_rvalid_i), .src_rdata_i(src_rdata_i),
        .cm_req_o(cm_req_o), .cm_addr_o(cm_addr_o), .cm_we_o(cm_we_o), .cm_be_o(cm_be_o),
        .cm_wdata_o(cm_wdata_o), .cm_gnt_i(cm_gnt_i)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_src, m_cm, m_xor;
    int          m_len, rd_idx, wr_idx, rd_at_hold;
    bit          aborting, m_busy, prev_sp, prev_cp, prev_done, saw_done, saw_aborted;
    logic [31:0] prev_sa, prev_ca, prev_cd;
    logic [31:0] rq[$];
    logic [31:0] rlog[$];
    logic [31:0] wlog[$];
    int          sg_pct = 100;
    int          cg_pct = 100;
    int          rv_pct = 100;
    bit          cm_hold = 1'b0;

    // Source memory contents: a fixed function of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [31:0] ea;
        if (!rst_ni) begin
            prev_sp = 0; prev_cp = 0; prev_done = 0; aborting = 0; m_busy = 0;
            return;
        end
        chk("cm_we", 64'(cm_we_o), 64'd1);
        chk("cm_be", 64'(cm_be_o), 64'hF);
        if (done_o) m_busy = 0;
        chk("busy", 64'(busy_o), 64'(m_busy));
        if (done_o && prev_done) chk("done_single_cycle", 64'd1, 64'd0);
        if (!busy_o) begin
            chk("src_req_when_idle", 64'(src_req_o), 64'd0);
            chk("cm_req_when_idle", 64'(cm_req_o), 64'd0);
        end
        if (prev_sp) begin
            chk("src_req_held", 64'(src_req_o), 64'd1);
            chk("src_addr_held", 64'(src_addr_o), 64'(prev_sa));
        end
        if (prev_cp) begin
            chk("cm_req_held", 64'(cm_req_o), 64'd1);
            chk("cm_addr_held", 64'(cm_addr_o), 64'(prev_ca));
            chk("cm_wdata_held", 64'(cm_wdata_o), 64'(prev_cd));
        end
        if (src_req_o && busy_o) begin
            if (aborting && !prev_sp) chk("new_read_after_abort", 64'd1, 64'd0);
            ea = m_src + 32'(rd_idx) * 32'd4;
            chk("src_addr", 64'(src_addr_o), 64'(ea));
            if (src_gnt_i) begin
                rq.push_back(mem_word(ea));
                rlog.push_back(src_addr_o);
                rd_idx++;
            end
        end
        if (cm_req_o && busy_o) begin
            if (aborting && !prev_cp) chk("new_write_after_abort", 64'd1, 64'd0);
            chk("cm_addr", 64'(cm_addr_o), 64'(m_cm + 32'(wr_idx) * 32'd4));
            chk("cm_wdata", 64'(cm_wdata_o), 64'(mem_word(m_src + 32'(wr_idx) * 32'd4)));
            if (cm_gnt_i) begin
                m_xor ^= cm_wdata_o;
                wlog.push_back(cm_addr_o);
                wr_idx++;
            end
        end
        if (busy_o && !aborting) chk("occupancy_le_depth", 64'(rd_idx - wr_idx <= FD), 64'd1);
        if (busy_o) chk("reads_le_len", 64'(rd_idx <= m_len), 64'd1);
        if (done_o) begin
            saw_done = 1;
            saw_aborted = aborted_o;
            chk("aborted_o", 64'(aborted_o), 64'(aborting));
            if (!aborting) chk("words_written", 64'(wr_idx), 64'(m_len));
            chk("all_rvalid_absorbed", 64'(rq.size()), 64'd0);
`ifdef CGRA_CMEM_LOADER_CHECKSUM_EN
            chk("checksum_at_done", 64'(checksum_o), 64'(m_xor));
`endif
        end
`ifndef CGRA_CMEM_LOADER_CHECKSUM_EN
        chk("checksum_zero", 64'(checksum_o), 64'd0);
`endif
        if (abort_i && busy_o && (wr_idx != m_len)) aborting = 1;
        prev_sp = src_req_o && !src_gnt_i;
        prev_sa = src_addr_o;
        prev_cp = cm_req_o && !cm_gnt_i;
        prev_ca = cm_addr_o;
        prev_cd = cm_wdata_o;
        prev_done = done_o;
        if (start_i && !busy_o && !done_o) begin
            m_src = src_base_i; m_cm = cm_base_i; m_len = int'(len_i);
            rd_idx = 0; wr_idx = 0; m_xor = 0; aborting = 0;
            m_busy = (len_i != 0);
        end
    endtask

    task automatic drive();
        src_gnt_i = ($urandom_range(99) < sg_pct);
        cm_gnt_i  = cm_hold ? 1'b0 : ($urandom_range(99) < cg_pct);
        if (rq.size() > 0 && $urandom_range(99) < rv_pct) begin
            src_rvalid_i = 1'b1;
            src_rdata_i  = rq.pop_front();
        end else begin
            src_rvalid_i = 1'b0;
            src_rdata_i  = $urandom;
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
        drive();
    endtask

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] c, input int len,
                            input int abort_wr, input int hold_cycles, output int done_cyc);
        bit fired = 0;
        rlog.delete();
        wlog.delete();
        src_base_i = s; cm_base_i = c; len_i = LW'(len); start_i = 1'b1;
        cm_hold = (hold_cycles > 0);
        step();
        start_i = 1'b0;
        saw_done = 0;
        saw_aborted = 0;
        done_cyc = -1;
        for (int cyc = 0; cyc < 3000 && !saw_done; cyc++) begin
            cm_hold = (cyc < hold_cycles);
            if (cyc == hold_cycles) rd_at_hold = rd_idx;
            abort_i = (abort_wr >= 0) && !fired && (wr_idx >= abort_wr);
            if (abort_i) fired = 1;
            step();
            if (saw_done) done_cyc = cyc;
        end
        abort_i = 1'b0;
        cm_hold = 1'b0;
        chk("done_within_budget", 64'(saw_done), 64'd1);
    endtask

    initial begin
        int          dc;
        logic [31:0] exp_w [4];
        logic [31:0] exp_r [4];
        logic [31:0] xw;
        rst_ni = 0; start_i = 0; abort_i = 0; src_base_i = 0; cm_base_i = 0; len_i = 0;
        src_gnt_i = 0; cm_gnt_i = 0; src_rvalid_i = 0; src_rdata_i = 0;
        repeat (3) step();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_aborted", 64'(aborted_o), 64'd0);
        chk("rst_src_req", 64'(src_req_o), 64'd0);
        chk("rst_src_addr", 64'(src_addr_o), 64'd0);
        chk("rst_cm_req", 64'(cm_req_o), 64'd0);
        chk("rst_cm_addr", 64'(cm_addr_o), 64'd0);
        chk("rst_cm_wdata", 64'(cm_wdata_o), 64'd0);
        chk("rst_checksum", 64'(checksum_o), 64'd0);
        chk("rst_cm_we", 64'(cm_we_o), 64'd1);
        chk("rst_cm_be", 64'(cm_be_o), 64'hF);
        rst_ni = 1;
        step();

        // Basic 4-word copy, zero-wait grants and 1-cycle rvalid.
        run_xfer(32'h1000, 32'h0, 4, -1, 0, dc);
        exp_w = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_r = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        chk("basic_write_count", 64'(wlog.size()), 64'd4);
        chk("basic_read_count", 64'(rlog.size()), 64'd4);
        if (wlog.size() == 4 && rlog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("basic_write_addr", 64'(wlog[i]), 64'(exp_w[i]));
                chk("basic_read_addr", 64'(rlog[i]), 64'(exp_r[i]));
            end
        end
        chk("basic_not_aborted", 64'(saw_aborted), 64'd0);

        // Zero length: done on the cycle after start, no bus traffic.
        run_xfer(32'h2000, 32'h40, 0, -1, 0, dc);
        chk("len0_done_latency", 64'(dc), 64'd0);
        chk("len0_no_reads", 64'(rlog.size()), 64'd0);
        chk("len0_no_writes", 64'(wlog.size()), 64'd0);

        // Write port stalled for 10 cycles: reads stop at FIFO depth, nothing lost.
        run_xfer(32'h5000, 32'h80, 6, -1, 10, dc);
        chk("stall_reads_issued", 64'(rd_at_hold), 64'(FD));
        chk("stall_all_written", 64'(wlog.size()), 64'd6);

        // Abort after two writes with a read in flight.
        run_xfer(32'h3000, 32'h100, 8, 2, 0, dc);
        chk("abort_flagged", 64'(saw_aborted), 64'd1);
        chk("abort_partial_writes", 64'(wlog.size() >= 2 && wlog.size() < 8), 64'd1);

        // Source address wraps through zero.
        run_xfer(32'hFFFF_FFF8, 32'h200, 4, -1, 0, dc);
        exp_r = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        chk("wrap_read_count", 64'(rlog.size()), 64'd4);
        if (rlog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("wrap_read_addr", 64'(rlog[i]), 64'(exp_r[i]));
        end
        step();
        xw = 0;
        for (int i = 0; i < 4; i++) xw ^= mem_word(exp_r[i]);
`ifdef CGRA_CMEM_LOADER_CHECKSUM_EN
        chk("wrap_checksum_held", 64'(checksum_o), 64'(xw));
`else
        chk("wrap_checksum_off", 64'(checksum_o), 64'd0);
`endif

        // Reset in the middle of a transfer; late responses must be ignored.
        src_base_i = 32'h4000; cm_base_i = 32'h300; len_i = 10; start_i = 1;
        step();
        start_i = 0;
        repeat (4) step();
        rst_ni = 0;
        step();
        chk("midrst_src_req", 64'(src_req_o), 64'd0);
        chk("midrst_cm_req", 64'(cm_req_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        rst_ni = 1;
        for (int k = 0; k < 50 && rq.size() > 0; k++) step();
        step();
        chk("midrst_idle_after_rsp", 64'(busy_o || src_req_o || cm_req_o), 64'd0);
        run_xfer(32'h6000, 32'h400, 5, -1, 0, dc);
        chk("midrst_recovery_writes", 64'(wlog.size()), 64'd5);

        // Randomized transfers with random bus timing and occasional abort.
        for (int t = 0; t < 14; t++) begin
            int len, ab;
            sg_pct = $urandom_range(30, 100);
            cg_pct = $urandom_range(30, 100);
            rv_pct = $urandom_range(30, 100);
            len = $urandom_range(0, 20);
            ab = ($urandom_range(3) == 0) ? $urandom_range(0, len) : -1;
            run_xfer({$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC, len, ab, 0, dc);
            if (ab < 0) chk("rand_all_written", 64'(wlog.size()), 64'(len));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cgra_cmem_loader.md
CGRA_CMEM_LOADER -- requirements
Module: cgra_cmem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: byte address width on both buses.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: transfer length width, in 32-bit words.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2: read-to-write buffer entries, minimum 2.
REQ-004 SHALL use one clock, clk_i; reset rst_ni is synchronous and active-low.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
  clk_i  in  1  clock
  rst_ni  in  1  synchronous active-low reset
  start_i  in  1  start a transfer; sampled only in IDLE
  abort_i  in  1  abort the active transfer
  src_base_i  in  ADDR_WIDTH  source byte address, word aligned
  cm_base_i  in  ADDR_WIDTH  context-memory byte address, word aligned
  len_i  in  LEN_WIDTH  number of words to copy
  busy_o  out  1  transfer in progress
  done_o  out  1  one-cycle completion pulse
  aborted_o  out  1  qualifies done_o; transfer was aborted
  checksum_o  out  32  XOR of all written words
  src_req_o  out  1  OBI read request toward system memory
  src_addr_o  out  ADDR_WIDTH  read address
  src_gnt_i  in  1  read grant
  src_rvalid_i  in  1  read data valid
  src_rdata_i  in  32  read data
  cm_req_o  out  1  OBI write request toward the CGRA context-memory slave port
  cm_addr_o  out  ADDR_WIDTH  write address
  cm_we_o  out  1  write enable; always 1
  cm_be_o  out  4  byte enables; always 4'hF
  cm_wdata_o  out  32  write data
  cm_gnt_i  in  1  write grant

Function
REQ-006 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE with start_i=1 and len_i!=0 SHALL latch src_base_i, cm_base_i and len_i, clear counters, and enter RUN on the next cycle.
REQ-008 IDLE with start_i=1 and len_i=0 SHALL enter DONE with no bus traffic.
REQ-009 busy_o SHALL be 1 exactly in RUN and DRAIN.
REQ-010 start_i outside IDLE SHALL be ignored.
REQ-011 In RUN, src_req_o SHALL be 1 when rd_issued<len and outstanding+fifo_count<FIFO_DEPTH.
REQ-012 src_addr_o SHALL equal src_base+4*rd_issued; rd_issued and outstanding SHALL increment on src_req_o&src_gnt_i.
REQ-013 Once src_req_o is asserted, it and src_addr_o SHALL hold stable until granted, including when abort_i arrives.
REQ-014 src_rvalid_i SHALL push src_rdata_i into the FIFO and decrement outstanding; overflow is impossible by REQ-011.
REQ-015 cm_req_o SHALL be 1 while the FIFO is non-empty; cm_wdata_o SHALL be the FIFO head, cm_addr_o SHALL be cm_base+4*wr_done, and the entry SHALL pop on cm_gnt_i.
REQ-016 The FIFO SHALL be registered: the earliest cm_req_o is the cycle after src_rvalid_i; simultaneous push and pop SHALL leave the count unchanged.
REQ-017 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-018 When wr_done reaches len in RUN, the FSM SHALL enter DONE.
REQ-019 abort_i in RUN SHALL enter DRAIN, block new reads, complete any asserted-but-ungranted requests, discard returning read data, and flush the FIFO without writing.
REQ-020 DRAIN SHALL exit to DONE when outstanding=0 and no request is pending; aborted_o SHALL then be 1 with done_o.
REQ-021 DONE SHALL last one cycle with done_o=1, then return to IDLE.

Reset
REQ-022 rst_ni=0 at a clock edge SHALL force IDLE, clear all counters and the FIFO, and drive every output to 0, except cm_we_o=1 and cm_be_o=4'hF.
REQ-023 Reset mid-transfer SHALL drop requests immediately; responses arriving after reset SHALL be ignored.

Configuration
REQ-024 With CGRA_CMEM_LOADER_CHECKSUM_EN defined, checksum_o SHALL clear on accepted start and XOR in cm_wdata_o on each cm_req_o&cm_gnt_i; it SHALL hold after DONE.
REQ-025 Without CGRA_CMEM_LOADER_CHECKSUM_EN, checksum_o SHALL be constant 0 and no checksum register SHALL exist.

Verification
REQ-026 Bench: len=4, src_base=0x1000, cm_base=0x0, zero-wait grants, 1-cycle rvalid -> writes 0x0/0x4/0x8/0xC with the source data, then one done_o pulse with aborted_o=0.
REQ-027 Bench: len=0 -> done_o one cycle after start, src_req_o and cm_req_o never asserted.
REQ-028 Bench: cm_gnt_i held low 10 cycles -> at most FIFO_DEPTH reads are issued, cm_req_o, cm_addr_o and cm_wdata_o stay stable, and no data is lost.
REQ-029 Bench: abort_i after 2 of 8 words, 1 read outstanding -> rvalid is absorbed, no further writes occur, and done_o=1 with aborted_o=1.
REQ-030 Bench: src_base=0xFFFFFFF8, len=4 -> reads from 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; with CHECKSUM_EN, checksum_o equals the XOR of the 4 words.
